// File: rtl/pix_roi_crop_pkg.sv
// Shared types and helpers for the pix_roi_crop ROI extractor.
package pix_roi_crop_pkg;

  localparam int unsigned CNT_W_DEF = 16;

  typedef enum logic [1:0] {
    S_WAIT_LOW = 2'd0,
    S_IDLE     = 2'd1,
    S_FRAME    = 2'd2,
    S_SKIP     = 2'd3
  } state_t;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_val;
    max_val = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_val) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/pix_pos_counter.sv
// fval/lval edge detection plus saturating column (beat) and line counters.
module pix_pos_counter
  import pix_roi_crop_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_fval,
  input  logic             i_lval,
  output logic [CNT_W-1:0] col,
  output logic [CNT_W-1:0] line_c,
  output logic             fval_rise_c,
  output logic             fval_fall_c,
  output logic             lval_fall_c
);

  logic             fval_q, fval_d;
  logic             lval_q, lval_d;
  logic [CNT_W-1:0] col_q, col_d;
  logic [CNT_W-1:0] line_q, line_d;

  always_comb begin : next_c
    fval_d      = i_fval;
    lval_d      = i_lval;
    fval_rise_c = i_fval & ~fval_q;
    fval_fall_c = ~i_fval & fval_q;
    lval_fall_c = ~i_lval & lval_q;
    col_d       = i_lval ? CNT_W'(sat_inc(32'(col_q), CNT_W)) : '0;
    line_d      = line_q;
    if (fval_rise_c) begin
      line_d = '0;
    end else if (lval_fall_c && i_fval) begin
      line_d = CNT_W'(sat_inc(32'(line_q), CNT_W));
    end
    // The first beat of a new frame already belongs to line 0.
    line_c = fval_rise_c ? '0 : line_q;
  end

  always_ff @(posedge clk) begin : regs
    if (reset) begin
      fval_q <= 1'b0;
      lval_q <= 1'b0;
      col_q  <= '0;
      line_q <= '0;
    end else begin
      fval_q <= fval_d;
      lval_q <= lval_d;
      col_q  <= col_d;
      line_q <= line_d;
    end
  end

  assign col = col_q;

endmodule

// File: rtl/pix_roi_crop.sv
// Crops a programmable ROI out of an fval/lval pixel stream and flags out-of-frame ROIs.
// Optional ROI_CROP_STAT_EN adds measured line width / frame height outputs.
module pix_roi_crop
  import pix_roi_crop_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 12,
  parameter int unsigned CHANNEL_NUM = 4,
  parameter int unsigned CNT_W       = CNT_W_DEF
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              i_fval,
  input  logic                              i_lval,
  input  logic [DATA_WIDTH*CHANNEL_NUM-1:0] iv_din,
  input  logic [CNT_W-1:0]                  iv_offset_x,
  input  logic [CNT_W-1:0]                  iv_roi_width,
  input  logic [CNT_W-1:0]                  iv_offset_y,
  input  logic [CNT_W-1:0]                  iv_roi_height,
  output logic                              o_fval,
  output logic                              o_lval,
  output logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_dout,
  output logic                              o_roi_err,
  output logic [CNT_W-1:0]                  ov_meas_width,
  output logic [CNT_W-1:0]                  ov_meas_height
);

  localparam int unsigned BUS_W = DATA_WIDTH * CHANNEL_NUM;
  localparam int unsigned SUM_W = CNT_W + 1;

  logic [CNT_W-1:0] col, line_c;
  logic             fval_rise_c, fval_fall_c, lval_fall_c;

  pix_pos_counter #(.CNT_W(CNT_W)) u_pos (
    .clk         (clk),
    .reset       (reset),
    .i_fval      (i_fval),
    .i_lval      (i_lval),
    .col         (col),
    .line_c      (line_c),
    .fval_rise_c (fval_rise_c),
    .fval_fall_c (fval_fall_c),
    .lval_fall_c (lval_fall_c)
  );

  logic [CNT_W-1:0] off_x_q, off_x_d, roi_w_q, roi_w_d;
  logic [CNT_W-1:0] off_y_q, off_y_d, roi_h_q, roi_h_d;
  logic [SUM_W-1:0] x_end_c, y_end_c;
  logic             row_in_roi_c, in_roi_c, active_c;
  state_t           state_q, state_d;
  logic             err_q, err_d;
  logic             o_fval_q, o_fval_d, o_lval_q, o_lval_d;
  logic             o_roi_err_q, o_roi_err_d;
  logic [BUS_W-1:0] dout_q, dout_d;

  // Shadow ROI: the value seen on the fval rise beat is used for the whole frame.
  always_comb begin : shadow_c
    off_x_d = off_x_q;
    roi_w_d = roi_w_q;
    off_y_d = off_y_q;
    roi_h_d = roi_h_q;
    if (fval_rise_c) begin
      off_x_d = iv_offset_x;
      roi_w_d = iv_roi_width;
      off_y_d = iv_offset_y;
      roi_h_d = iv_roi_height;
    end
  end

  always_comb begin : match_c
    x_end_c      = SUM_W'(off_x_d) + SUM_W'(roi_w_d);
    y_end_c      = SUM_W'(off_y_d) + SUM_W'(roi_h_d);
    row_in_roi_c = (line_c >= off_y_d) && (SUM_W'(line_c) < y_end_c);
    in_roi_c     = i_lval && (col >= off_x_d) && (SUM_W'(col) < x_end_c) && row_in_roi_c;
  end

  always_comb begin : fsm_c
    state_d     = state_q;
    err_d       = err_q;
    o_roi_err_d = 1'b0;
    unique case (state_q)
      S_WAIT_LOW: if (!i_fval) state_d = S_IDLE;
      S_IDLE: begin
        if (fval_rise_c) begin
          state_d = ((roi_w_d != '0) && (roi_h_d != '0)) ? S_FRAME : S_SKIP;
        end
      end
      S_FRAME, S_SKIP: if (fval_fall_c) state_d = S_IDLE;
      default: state_d = S_WAIT_LOW;
    endcase

    if (fval_rise_c) err_d = 1'b0;
    if (state_q == S_FRAME) begin
      if (lval_fall_c && row_in_roi_c && (SUM_W'(col) < x_end_c)) err_d = 1'b1;
      if (fval_fall_c && (SUM_W'(line_c) < y_end_c)) err_d = 1'b1;
      o_roi_err_d = fval_fall_c && err_d;
    end

    active_c = (state_d == S_FRAME) && i_fval;
    o_fval_d = active_c;
    o_lval_d = active_c && in_roi_c;
    dout_d   = o_lval_d ? iv_din : '0;
  end

  always_ff @(posedge clk) begin : regs
    if (reset) begin
      state_q     <= S_WAIT_LOW;
      off_x_q     <= '0;
      roi_w_q     <= '0;
      off_y_q     <= '0;
      roi_h_q     <= '0;
      err_q       <= 1'b0;
      o_fval_q    <= 1'b0;
      o_lval_q    <= 1'b0;
      o_roi_err_q <= 1'b0;
      dout_q      <= '0;
    end else begin
      state_q     <= state_d;
      off_x_q     <= off_x_d;
      roi_w_q     <= roi_w_d;
      off_y_q     <= off_y_d;
      roi_h_q     <= roi_h_d;
      err_q       <= err_d;
      o_fval_q    <= o_fval_d;
      o_lval_q    <= o_lval_d;
      o_roi_err_q <= o_roi_err_d;
      dout_q      <= dout_d;
    end
  end

  assign o_fval    = o_fval_q;
  assign o_lval    = o_lval_q;
  assign ov_dout   = dout_q;
  assign o_roi_err = o_roi_err_q;

`ifdef ROI_CROP_STAT_EN
  logic [CNT_W-1:0] meas_w_q, meas_w_d, meas_h_q, meas_h_d;

  // Final beat count of each line and line count of each frame, held until replaced.
  always_comb begin : meas_c
    meas_w_d = meas_w_q;
    meas_h_d = meas_h_q;
    if (lval_fall_c && i_fval) meas_w_d = col;
    if (fval_fall_c) meas_h_d = line_c;
  end

  always_ff @(posedge clk) begin : meas_regs
    if (reset) begin
      meas_w_q <= '0;
      meas_h_q <= '0;
    end else begin
      meas_w_q <= meas_w_d;
      meas_h_q <= meas_h_d;
    end
  end

  assign ov_meas_width  = meas_w_q;
  assign ov_meas_height = meas_h_q;
`else
  assign ov_meas_width  = '0;
  assign ov_meas_height = '0;
`endif

endmodule

// File: tb/tb_pix_roi_crop.sv
// Scoreboard bench for pix_roi_crop: frame-level reference model feeds queues, a monitor checks output.
module tb_pix_roi_crop;

  localparam int unsigned DW = 12;
  localparam int unsigned CH = 4;
  localparam int unsigned CW = 16;
  localparam int unsigned BW = DW * CH;

  logic          clk;
  logic          reset;
  logic          i_fval, i_lval;
  logic [BW-1:0] iv_din;
  logic [CW-1:0] iv_offset_x, iv_roi_width, iv_offset_y, iv_roi_height;
  logic          o_fval, o_lval, o_roi_err;
  logic [BW-1:0] ov_dout;
  logic [CW-1:0] ov_meas_width, ov_meas_height;

  pix_roi_crop #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .CNT_W(CW)) dut (
    .clk            (clk),
    .reset          (reset),
    .i_fval         (i_fval),
    .i_lval         (i_lval),
    .iv_din         (iv_din),
    .iv_offset_x    (iv_offset_x),
    .iv_roi_width   (iv_roi_width),
    .iv_offset_y    (iv_offset_y),
    .iv_roi_height  (iv_roi_height),
    .o_fval         (o_fval),
    .o_lval         (o_lval),
    .ov_dout        (ov_dout),
    .o_roi_err      (o_roi_err),
    .ov_meas_width  (ov_meas_width),
    .ov_meas_height (ov_meas_height)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [BW-1:0] data;
    int unsigned   cyc;
  } beat_t;

  typedef struct {
    int unsigned len;
    bit          err;
    int unsigned width;
    int unsigned height;
  } frame_t;

  beat_t       beat_q[$];
  frame_t      frame_q[$];
  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  logic        rst_s    = 1'b1;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_s <= reset;
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got unexpected output, expected none (cycle %0d)", name, cyc);
  endtask

  // Monitor: consumes expectations whenever the DUT presents a beat or ends a frame.
  initial begin : monitor
    bit          prev_fv;
    int unsigned fv_len;
    beat_t       b;
    frame_t      f;
    prev_fv = 1'b0;
    fv_len  = 0;
    forever begin
      @(negedge clk);
      if (rst_s) begin
        check("reset_outputs", 64'({o_fval, o_lval, o_roi_err, ov_dout}), 64'(0));
        prev_fv = 1'b0;
        fv_len  = 0;
        continue;
      end
      if (o_lval) begin
        check("lval_inside_fval", 64'(o_fval), 64'(1));
        if (beat_q.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          b = beat_q.pop_front();
          check("beat_data", 64'(ov_dout), 64'(b.data));
          check("beat_latency", 64'(cyc), 64'(b.cyc + 1));
        end
      end else begin
        check("dout_zero_idle", 64'(ov_dout), 64'(0));
      end
      if (o_fval) fv_len++;
      if (prev_fv && !o_fval) begin
        if (frame_q.size() == 0) begin
          fail_now("unexpected_frame");
        end else begin
          f = frame_q.pop_front();
          check("fval_len", 64'(fv_len), 64'(f.len));
          check("roi_err", 64'(o_roi_err), 64'(f.err));
`ifdef ROI_CROP_STAT_EN
          check("meas_width", 64'(ov_meas_width), 64'(f.width));
          check("meas_height", 64'(ov_meas_height), 64'(f.height));
`else
          check("meas_width_off", 64'(ov_meas_width), 64'(0));
          check("meas_height_off", 64'(ov_meas_height), 64'(0));
`endif
        end
        fv_len = 0;
      end else begin
        check("roi_err_quiet", 64'(o_roi_err), 64'(0));
      end
      prev_fv = o_fval;
    end
  end

  initial begin : watchdog
    repeat (80000) @(posedge clk);
    $display("FAIL watchdog: got no end of stimulus, expected finish within 80000 cycles");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

  task automatic step(input bit fv, input bit lv, input logic [BW-1:0] d, input bit rs);
    @(negedge clk);
    i_fval = fv;
    i_lval = lv;
    iv_din = d;
    reset  = rs;
  endtask

  function automatic logic [BW-1:0] rnd_beat();
    return BW'({$urandom, $urandom});
  endfunction

  task automatic set_roi(input int unsigned ox, input int unsigned w,
                         input int unsigned oy, input int unsigned h);
    iv_offset_x   = CW'(ox);
    iv_roi_width  = CW'(w);
    iv_offset_y   = CW'(oy);
    iv_roi_height = CW'(h);
  endtask

  // One frame of nlines x ncols beats; the model crops with the ROI present at fval rise.
  task automatic run_frame(input int unsigned ncols, input int unsigned nlines,
                           input int unsigned hbl, input int unsigned vbl,
                           input int rst_line, input int chg_x, input bit stray);
    int unsigned   ox, w, oy, h, len;
    bit            skip, drop, err;
    logic [BW-1:0] d;
    ox   = iv_offset_x;
    w    = iv_roi_width;
    oy   = iv_offset_y;
    h    = iv_roi_height;
    skip = (w == 0) || (h == 0);
    drop = (rst_line >= 0);
    err  = 1'b0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    len = 2;
    for (int unsigned l = 0; l < nlines; l++) begin
      if (int'(l) == rst_line) begin
        repeat (3) begin
          step(1'b1, 1'b0, '0, 1'b1);
          len++;
        end
      end
      if (chg_x >= 0 && l == 2) iv_offset_x = CW'(chg_x);
      for (int unsigned c = 0; c < ncols; c++) begin
        d = rnd_beat();
        step(1'b1, 1'b1, d, 1'b0);
        len++;
        if (!skip && !drop && c >= ox && c < ox + w && l >= oy && l < oy + h)
          beat_q.push_back('{data: d, cyc: cyc});
      end
      repeat (hbl) begin
        step(1'b1, 1'b0, '0, 1'b0);
        len++;
      end
      if (!skip && l >= oy && l < oy + h && ncols < ox + w) err = 1'b1;
    end
    if (!skip && nlines < oy + h) err = 1'b1;
    if (!skip && !drop) frame_q.push_back('{len: len, err: err, width: ncols, height: nlines});
    if (stray && vbl >= 4) begin
      step(1'b0, 1'b0, '0, 1'b0);
      step(1'b0, 1'b1, rnd_beat(), 1'b0);
      step(1'b0, 1'b1, rnd_beat(), 1'b0);
      repeat (vbl - 3) step(1'b0, 1'b0, '0, 1'b0);
    end else begin
      repeat (vbl) step(1'b0, 1'b0, '0, 1'b0);
    end
  endtask

  initial begin : stimulus
    int unsigned nc, nl;
    reset  = 1'b1;
    i_fval = 1'b0;
    i_lval = 1'b0;
    iv_din = '0;
    set_roi(0, 0, 0, 0);
    repeat (4) step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0);

    set_roi(2, 4, 1, 3);
    run_frame(16, 8, 3, 3, -1, -1, 1'b0);
    set_roi(2, 0, 1, 3);
    run_frame(16, 8, 3, 3, -1, -1, 1'b0);
    set_roi(2, 4, 1, 3);
    run_frame(16, 8, 3, 3, -1, -1, 1'b0);
    set_roi(14, 4, 1, 3);
    run_frame(16, 8, 3, 3, -1, -1, 1'b0);
    set_roi(2, 4, 4, 3);
    run_frame(16, 8, 3, 3, 3, -1, 1'b0);
    set_roi(2, 4, 1, 3);
    run_frame(16, 8, 3, 3, -1, -1, 1'b0);
    run_frame(16, 8, 3, 3, -1, 5, 1'b0);
    run_frame(16, 8, 3, 3, -1, -1, 1'b0);
    set_roi(0, 12, 0, 4);
    repeat (3) run_frame(12, 4, 1, 1, -1, -1, 1'b0);
    set_roi(3, 2, 2, 9);
    run_frame(8, 6, 2, 5, -1, -1, 1'b1);

    for (int i = 0; i < 40; i++) begin
      nc = $urandom_range(20, 4);
      nl = $urandom_range(8, 1);
      set_roi($urandom_range(nc + 1, 0), $urandom_range(6, 0),
              $urandom_range(nl, 0), $urandom_range(4, 0));
      run_frame(nc, nl, $urandom_range(4, 1), $urandom_range(6, 1), -1, -1, 1'($urandom));
    end

    repeat (10) step(1'b0, 1'b0, '0, 1'b0);
    check("beats_drained", 64'(beat_q.size()), 64'(0));
    check("frames_drained", 64'(frame_q.size()), 64'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
